calendar_timekeeper: RTL and testbench
======================================

// Module: calendar_timekeeper
// PURPOSE
//  Parametrised time-of-day and calendar core. A 1 Hz tick is divided internally from clk.
//  The core keeps sec/min/hour/day/month/year with full Gregorian leap rules and a configurable year window.
//  Every field is user-settable through up/down pulses and a field select.
//  Drives the display/format stage. up/down/set inputs are debounced single-cycle pulses from the button block.
// PARAMETERS
//  CLK_HZ    50_000_000  clk cycles per 1 s tick (>=2)
//  YEAR_W    12          year output width; must hold YEAR_MAX
//  YEAR_MIN  2000        first year of the window; reset year
//  YEAR_MAX  2999        last year; wraps to YEAR_MIN
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  set_mode   in   1       1 = manual set; timekeeping frozen
//  sel        in   3       field: 1 sec,2 min,3 hour,4 day,5 month,6 year; 0/7 none
//  up         in   1       one-cycle increment pulse
//  down       in   1       one-cycle decrement pulse
//  second     out  6       0..59
//  minute     out  6       0..59
//  hour       out  5       0..23
//  day        out  5       1..max_day
//  month      out  4       1..12
//  year       out  YEAR_W  YEAR_MIN..YEAR_MAX
//  leap       out  1       current year is leap (combinational from year)
//  tick       out  1       one-cycle pulse on each 1 s advance
//  rollover   out  1       one-cycle pulse when year wraps YEAR_MAX->YEAR_MIN
// BEHAVIOUR
//  Reset: 00:00:00, day 1, month 1, year YEAR_MIN; divider 0; tick/rollover 0.
//  Reset wins over all other inputs on the same edge.
//  Divider: counts 0..CLK_HZ-1. tick asserts on the edge where the count wraps.
//  Divider is held at 0 while set_mode=1, so the first tick comes exactly CLK_HZ cycles after set_mode falls.
//  Run (set_mode=0), on tick: second+1. Carries ripple through all fields on the SAME edge:
//   - 59->0 carries into minute; minute 59->0 carries into hour.
//   - hour 23->0 carries into day; day max_day->1 carries into month.
//   - month 12->1 carries into year; YEAR_MAX->YEAR_MIN pulses rollover.
//  max_day: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if leap else 28.
//  leap = (y%4==0 && y%100!=0) || y%400==0.
//  Set (set_mode=1): up/down acts on the selected field only, registered on the next edge (1-cycle latency).
//   - Field wraps within its own range; no carry/borrow into other fields.
//   - Ranges: day 1<->max_day, month 12<->1, year YEAR_MAX<->YEAR_MIN.
//   - up and down in the same cycle: no change. sel 0/7: up/down ignored.
//  Day clamp: if a month or year edit makes day > new max_day, day becomes new max_day on the same edge.
//   Example: 31 Jan +month -> 28/29 Feb. 29 Feb 2024 +year -> 28 Feb 2025.
//  up/down while set_mode=0 are ignored. tick never asserts while set_mode=1.
//  set_mode toggling mid-second discards the partial divider count; fields keep their values.
//  All outputs are registered except leap.
// CONFIGURATION
//  ALARM_EN defined: adds these ports:
//   - alarm_arm  in  1
//   - alarm_hour in  5
//   - alarm_min  in  6
//   - alarm_hit  out 1
//  alarm_hit pulses for one cycle on the tick edge where the time becomes alarm_hour:alarm_min:00 while alarm_arm=1.
//  Setting the time to the alarm value in set mode never fires. alarm_hit resets to 0.
//  ALARM_EN undefined: alarm ports and logic are absent. Core behaviour is identical.
// TESTING  (bench uses CLK_HZ=4)
//  1. Assert rst 1 cycle -> 00:00:00 01/01/2000, tick=0, leap=1. After 4 cycles: second=1, tick high for 1 cycle.
//  2. Set 23:59:59 31/12/2999, then drop set_mode. After 4 cycles -> 00:00:00 01/01/2000 and rollover=1 for 1 cycle.
//  3. 23:59:59 on 28/02: year 2100 -> 01/03; year 2000 -> 29/02; year 2023 -> 01/03. leap=0,1,0 respectively.
//  4. Set mode on 31/01/2023, sel=5 up -> 28/02. sel=6 on 29/02/2024 up -> 28/02/2025. up+down same cycle -> no change.
//  5. set_mode high 40 cycles -> no tick, fields frozen. sel=1 down at second 0 -> 59 with minute unchanged.
//     up with sel=0 -> no change.
//  6. ALARM_EN, armed 07:30: tick from 07:29:59 -> alarm_hit 1 cycle. Disarmed -> 0. Set-mode entry of 07:30:00 -> 0.

Source files
------------

// File: rtl/calendar_timekeeper.sv
// Time-of-day and Gregorian calendar core with a divided 1 s tick and per-field manual set.
// Optional alarm comparator is built when ALARM_EN is defined.
module calendar_timekeeper #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int YEAR_W   = 12,
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_mode,
  input  logic [2:0]        sel,
  input  logic              up,
  input  logic              down,
`ifdef ALARM_EN
  input  logic              alarm_arm,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_min,
  output logic              alarm_hit,
`endif
  output logic [5:0]        second,
  output logic [5:0]        minute,
  output logic [4:0]        hour,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic              tick,
  output logic              rollover
);
  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0]     DIV_LAST = CW'(CLK_HZ - 1);
  localparam logic [YEAR_W-1:0] Y_MIN    = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX    = YEAR_W'(YEAR_MAX);

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] v;
    v = 32'(y);
    return (((v % 32'd4) == 32'd0) && ((v % 32'd100) != 32'd0)) || ((v % 32'd400) == 32'd0);
  endfunction

  function automatic logic [4:0] max_day(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return lp ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [CW-1:0]     div_cnt;
  logic              div_wrap, adj, n_roll;
  logic [5:0]        n_sec, n_min;
  logic [4:0]        n_hour, n_day, cur_md, new_md;
  logic [3:0]        n_month;
  logic [YEAR_W-1:0] n_year;

  assign leap     = is_leap(year);
  assign cur_md   = max_day(month, leap);
  assign div_wrap = !set_mode && (div_cnt == DIV_LAST);
  assign adj      = set_mode && (up ^ down);

  always_comb begin
    n_sec   = second;
    n_min   = minute;
    n_hour  = hour;
    n_day   = day;
    n_month = month;
    n_year  = year;
    n_roll  = 1'b0;
    new_md  = cur_md;
    if (div_wrap) begin
      // full carry ripple settles in one edge
      if (second != 6'd59) n_sec = second + 6'd1;
      else begin
        n_sec = 6'd0;
        if (minute != 6'd59) n_min = minute + 6'd1;
        else begin
          n_min = 6'd0;
          if (hour != 5'd23) n_hour = hour + 5'd1;
          else begin
            n_hour = 5'd0;
            if (day != cur_md) n_day = day + 5'd1;
            else begin
              n_day = 5'd1;
              if (month != 4'd12) n_month = month + 4'd1;
              else begin
                n_month = 4'd1;
                if (year != Y_MAX) n_year = year + YEAR_W'(1);
                else begin
                  n_year = Y_MIN;
                  n_roll = 1'b1;
                end
              end
            end
          end
        end
      end
    end else if (adj) begin
      case (sel)
        3'd1: n_sec   = up ? ((second == 6'd59) ? 6'd0 : second + 6'd1)
                           : ((second == 6'd0) ? 6'd59 : second - 6'd1);
        3'd2: n_min   = up ? ((minute == 6'd59) ? 6'd0 : minute + 6'd1)
                           : ((minute == 6'd0) ? 6'd59 : minute - 6'd1);
        3'd3: n_hour  = up ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1)
                           : ((hour == 5'd0) ? 5'd23 : hour - 5'd1);
        3'd4: n_day   = up ? ((day >= cur_md) ? 5'd1 : day + 5'd1)
                           : ((day <= 5'd1) ? cur_md : day - 5'd1);
        3'd5: n_month = up ? ((month == 4'd12) ? 4'd1 : month + 4'd1)
                           : ((month == 4'd1) ? 4'd12 : month - 4'd1);
        3'd6: n_year  = up ? ((year == Y_MAX) ? Y_MIN : year + YEAR_W'(1))
                           : ((year == Y_MIN) ? Y_MAX : year - YEAR_W'(1));
        default: ;
      endcase
      // month/year edits can shrink the month under the current day
      new_md = max_day(n_month, is_leap(n_year));
      if (n_day > new_md) n_day = new_md;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      tick     <= 1'b0;
      rollover <= 1'b0;
      second   <= 6'd0;
      minute   <= 6'd0;
      hour     <= 5'd0;
      day      <= 5'd1;
      month    <= 4'd1;
      year     <= Y_MIN;
    end else begin
      div_cnt  <= (set_mode || div_wrap) ? '0 : div_cnt + CW'(1);
      tick     <= div_wrap;
      rollover <= n_roll;
      second   <= n_sec;
      minute   <= n_min;
      hour     <= n_hour;
      day      <= n_day;
      month    <= n_month;
      year     <= n_year;
    end
  end

`ifdef ALARM_EN
  // only a running tick can fire; set-mode edits never reach here
  always_ff @(posedge clk) begin
    if (rst) alarm_hit <= 1'b0;
    else     alarm_hit <= div_wrap && alarm_arm && (n_hour == alarm_hour) &&
                          (n_min == alarm_min) && (n_sec == 6'd0);
  end
`endif
endmodule

// File: tb/tb_calendar_timekeeper.sv
// Directed bench for calendar_timekeeper (CLK_HZ=4); expected states go through a scoreboard queue.
module tb_calendar_timekeeper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_mode = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic [5:0]  second, minute;
  logic [4:0]  hour, day;
  logic [3:0]  month;
  logic [11:0] year;
  logic        leap, tick, rollover;
`ifdef ALARM_EN
  logic        alarm_arm = 1'b0;
  logic [4:0]  alarm_hour = 5'd0;
  logic [5:0]  alarm_min = 6'd0;
  logic        alarm_hit;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [37:0] st;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  calendar_timekeeper #(.CLK_HZ(4), .YEAR_W(12), .YEAR_MIN(2000), .YEAR_MAX(2999)) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .sel(sel), .up(up), .down(down),
`ifdef ALARM_EN
    .alarm_arm(alarm_arm), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_hit(alarm_hit),
`endif
    .second(second), .minute(minute), .hour(hour), .day(day), .month(month), .year(year),
    .leap(leap), .tick(tick), .rollover(rollover)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int h, input int m, input int s,
                              input int d, input int mo, input int y);
    exp_t e;
    e.tag = tag;
    e.st  = {5'(h), 6'(m), 6'(s), 5'(d), 4'(mo), 12'(y)};
    sb.push_back(e);
  endtask

  task automatic check_state();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, 64'({hour, minute, second, day, month, year}), 64'(e.st));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] s, input logic u, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      sel = s; up = u; down = d;
      @(negedge clk);
      up = 1'b0; down = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks_seen;
    // reset and first tick
    expect_state("reset_state", 0, 0, 0, 1, 1, 2000);
    @(negedge clk);
    rst = 1'b0;
    check_state();
    chk("reset_tick", 64'(tick), 64'd0);
    chk("reset_leap", 64'(leap), 64'd1);
    chk("reset_rollover", 64'(rollover), 64'd0);
    step(3);
    chk("tick_early", 64'(tick), 64'd0);
    expect_state("first_tick_state", 0, 0, 1, 1, 1, 2000);
    step(1);
    check_state();
    chk("first_tick", 64'(tick), 64'd1);
    step(1);
    chk("tick_one_cycle", 64'(tick), 64'd0);

    // freeze in set mode, second field wrap, ignored edits
    set_mode = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    chk("no_tick_in_set", 64'(ticks_seen), 64'd0);
    expect_state("frozen", 0, 0, 1, 1, 1, 2000);
    check_state();
    press(3'd1, 1'b0, 1'b1, 2);
    expect_state("sec_down_wrap", 0, 0, 59, 1, 1, 2000);
    check_state();
    press(3'd0, 1'b1, 1'b0, 1);
    press(3'd7, 1'b0, 1'b1, 1);
    expect_state("sel_none_ignored", 0, 0, 59, 1, 1, 2000);
    check_state();
    press(3'd1, 1'b1, 1'b1, 1);
    expect_state("up_down_same", 0, 0, 59, 1, 1, 2000);
    check_state();

    // year window rollover
    press(3'd3, 1'b0, 1'b1, 1);
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd5, 1'b0, 1'b1, 1);
    press(3'd4, 1'b0, 1'b1, 1);
    press(3'd6, 1'b0, 1'b1, 1);
    expect_state("set_end_of_window", 23, 59, 59, 31, 12, 2999);
    check_state();
    chk("leap_2999", 64'(leap), 64'd0);
    set_mode = 1'b0;
    step(3);
    chk("rollover_early", 64'(rollover), 64'd0);
    expect_state("rollover_state", 0, 0, 0, 1, 1, 2000);
    step(1);
    check_state();
    chk("rollover_pulse", 64'(rollover), 64'd1);
    chk("rollover_tick", 64'(tick), 64'd1);
    step(1);
    chk("rollover_one_cycle", 64'(rollover), 64'd0);
    set_mode = 1'b1;

    // leap years: 2000 leap, 2100 not, 2023 not
    press(3'd3, 1'b0, 1'b1, 1);
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd1, 1'b0, 1'b1, 1);
    press(3'd5, 1'b1, 1'b0, 1);
    press(3'd4, 1'b0, 1'b1, 2);
    expect_state("set_feb28_2000", 23, 59, 59, 28, 2, 2000);
    check_state();
    set_mode = 1'b0;
    step(4);
    expect_state("feb29_2000", 0, 0, 0, 29, 2, 2000);
    check_state();
    chk("leap_2000", 64'(leap), 64'd1);
    set_mode = 1'b1;
    press(3'd3, 1'b0, 1'b1, 1);
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd1, 1'b0, 1'b1, 1);
    press(3'd4, 1'b0, 1'b1, 1);
    press(3'd6, 1'b1, 1'b0, 100);
    expect_state("set_feb28_2100", 23, 59, 59, 28, 2, 2100);
    check_state();
    chk("leap_2100", 64'(leap), 64'd0);
    set_mode = 1'b0;
    step(4);
    expect_state("mar1_2100", 0, 0, 0, 1, 3, 2100);
    check_state();
    set_mode = 1'b1;
    press(3'd3, 1'b0, 1'b1, 1);
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd1, 1'b0, 1'b1, 1);
    press(3'd5, 1'b0, 1'b1, 1);
    press(3'd4, 1'b0, 1'b1, 1);
    press(3'd6, 1'b0, 1'b1, 77);
    expect_state("set_feb28_2023", 23, 59, 59, 28, 2, 2023);
    check_state();
    chk("leap_2023", 64'(leap), 64'd0);
    set_mode = 1'b0;
    step(4);
    expect_state("mar1_2023", 0, 0, 0, 1, 3, 2023);
    check_state();
    set_mode = 1'b1;

    // day clamp on month and year edits
    press(3'd5, 1'b0, 1'b1, 2);
    press(3'd4, 1'b0, 1'b1, 1);
    expect_state("jan31_2023", 0, 0, 0, 31, 1, 2023);
    check_state();
    press(3'd5, 1'b1, 1'b0, 1);
    expect_state("clamp_month", 0, 0, 0, 28, 2, 2023);
    check_state();
    press(3'd6, 1'b1, 1'b0, 1);
    press(3'd4, 1'b1, 1'b0, 1);
    expect_state("feb29_2024", 0, 0, 0, 29, 2, 2024);
    check_state();
    press(3'd6, 1'b1, 1'b0, 1);
    expect_state("clamp_year", 0, 0, 0, 28, 2, 2025);
    check_state();
    press(3'd6, 1'b1, 1'b1, 1);
    expect_state("year_up_down_same", 0, 0, 0, 28, 2, 2025);
    check_state();
    set_mode = 1'b0;
    sel = 3'd1; up = 1'b1;
    step(1);
    up = 1'b0;
    expect_state("up_in_run_ignored", 0, 0, 0, 28, 2, 2025);
    check_state();
    set_mode = 1'b1;

`ifdef ALARM_EN
    alarm_arm = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    press(3'd3, 1'b1, 1'b0, 7);
    press(3'd2, 1'b1, 1'b0, 30);
    chk("alarm_set_entry", 64'(alarm_hit), 64'd0);
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd1, 1'b0, 1'b1, 1);
    set_mode = 1'b0;
    step(3);
    chk("alarm_early", 64'(alarm_hit), 64'd0);
    expect_state("alarm_time", 7, 30, 0, 28, 2, 2025);
    step(1);
    check_state();
    chk("alarm_hit", 64'(alarm_hit), 64'd1);
    step(1);
    chk("alarm_one_cycle", 64'(alarm_hit), 64'd0);
    set_mode = 1'b1;
    press(3'd2, 1'b0, 1'b1, 1);
    press(3'd1, 1'b0, 1'b1, 1);
    alarm_arm = 1'b0;
    set_mode = 1'b0;
    step(4);
    chk("alarm_disarmed", 64'(alarm_hit), 64'd0);
    set_mode = 1'b1;
`endif

    // reset beats a simultaneous edit
    sel = 3'd6; up = 1'b1; rst = 1'b1;
    step(1);
    rst = 1'b0; up = 1'b0; set_mode = 1'b0;
    expect_state("reset_wins", 0, 0, 0, 1, 1, 2000);
    check_state();
    step(3);
    chk("post_reset_no_tick", 64'(tick), 64'd0);
    step(1);
    chk("post_reset_tick", 64'(tick), 64'd1);
    chk("post_reset_second", 64'(second), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
